// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder and 4-state hard-decision Viterbi decoder.
// Optional corrected-bit estimate on err_cnt_o when VITERBI_ERR_CNT_EN is defined.
module viterbi_codec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_valid_o,
  output logic       dec_d_o
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  localparam int CW    = PM_W + 1;
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]  PM_MAX  = '1;
  localparam logic [CW-1:0]    PM_SAT  = {1'b0, PM_MAX};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);

  function automatic logic [1:0] exp_sym(input logic [1:0] s, input logic d);
    return {d ^ s[1] ^ s[0], d ^ s[0]};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Encoder
  logic [1:0] enc_s_q, enc_s_d;
  logic [1:0] enc_sym_q, enc_sym_d;
  logic       enc_valid_q;

  always_comb begin
    enc_s_d   = enc_s_q;
    enc_sym_d = enc_sym_q;
    if (enc_enable_i) begin
      enc_sym_d = exp_sym(enc_s_q, enc_d_i);
      enc_s_d   = {enc_d_i, enc_s_q[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_s_q     <= 2'b00;
      enc_sym_q   <= 2'b00;
      enc_valid_q <= 1'b0;
    end else begin
      enc_s_q     <= enc_s_d;
      enc_sym_q   <= enc_sym_d;
      enc_valid_q <= enc_enable_i;
    end
  end

  assign enc_valid_o = enc_valid_q;
  assign enc_d_o     = enc_sym_q;

  // Decoder state
  logic [PM_W-1:0]     pm_q[4], pm_d[4];
  logic [TB_DEPTH-1:0] surv_q[4], surv_d[4];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dec_bit_q, dec_bit_d;
  logic                dec_valid_q, dec_valid_d;

  logic [1:0]    bm0[4], bm1[4];
  logic [CW-1:0] cand0[4], cand1[4], acc[4];
  logic          sel[4];
  logic [CW-1:0] min_v, diff;
  logic [1:0]    best;

  // Add-compare-select: next state {d,a} is reached from {a,0} or {a,1}
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      bm0[ns]   = hamming(dec_d_i, exp_sym({ns[0], 1'b0}, ns[1]));
      bm1[ns]   = hamming(dec_d_i, exp_sym({ns[0], 1'b1}, ns[1]));
      cand0[ns] = {1'b0, pm_q[{ns[0], 1'b0}]} + {{(CW-2){1'b0}}, bm0[ns]};
      cand1[ns] = {1'b0, pm_q[{ns[0], 1'b1}]} + {{(CW-2){1'b0}}, bm1[ns]};
      sel[ns]   = cand1[ns] < cand0[ns];
      acc[ns]   = sel[ns] ? cand1[ns] : cand0[ns];
    end
  end

  // Strict compare keeps the lowest index on ties
  always_comb begin
    min_v = acc[0];
    best  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acc[i] < min_v) begin
        min_v = acc[i];
        best  = 2'(i);
      end
    end
  end

  always_comb begin
    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = 1'b0;
    diff        = '0;
    if (dec_enable_i) begin
      for (int ns = 0; ns < 4; ns++) begin
        diff       = acc[ns] - min_v;
        pm_d[ns]   = (diff > PM_SAT) ? PM_MAX : diff[PM_W-1:0];
        // Oldest bit falls off the top of the survivor
        surv_d[ns] = TB_DEPTH'({surv_q[{ns[0], sel[ns]}], ns[1]});
      end
      dec_bit_d   = surv_d[best][TB_DEPTH-1];
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      dec_valid_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q[0]     <= '0;
      pm_q[1]     <= PM_W'(4);
      pm_q[2]     <= PM_W'(4);
      pm_q[3]     <= PM_W'(4);
      for (int i = 0; i < 4; i++) surv_q[i] <= '0;
      cnt_q       <= '0;
      dec_bit_q   <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_d;
      dec_bit_q   <= dec_bit_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign dec_valid_o = dec_valid_q;
  assign dec_d_o     = dec_bit_q;

`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [1:0]  best_bm;
  logic [16:0] err_sum;

  always_comb begin
    best_bm   = sel[best] ? bm1[best] : bm0[best];
    err_sum   = {1'b0, err_cnt_q} + {15'd0, best_bm};
    err_cnt_d = err_cnt_q;
    if (dec_enable_i) err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_codec.sv
// Scoreboard bench for viterbi_codec: encoder vector, loopback with errors, gaps and reset.
module tb_viterbi_codec;
  localparam int TBD   = 16;
  localparam int N_SYM = 760;
  localparam int MAX_CYC = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_enable_i, enc_d_i, enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i;
  logic [1:0] dec_d_i;
  logic       dec_valid_o, dec_d_o;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  always #5 clk = ~clk;

  viterbi_codec #(.TB_DEPTH(TBD), .PM_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_valid_o  (dec_valid_o),
    .dec_d_o      (dec_d_o)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  bit [1:0] m_s;
  bit       bit_q[$];
  bit [1:0] sym_q[$];
  bit       pend_v;
  bit [1:0] pend_d;
  int       dec_cnt, n_out, n_cons;

  bit       kv_bits[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  bit [1:0] kv_exp[6]  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

  task automatic do_reset();
    rst          = 1'b1;
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
    @(posedge clk); #1;
    chk("rst_enc_valid", 32'(enc_valid_o), 32'(0));
    chk("rst_enc_sym",   32'(enc_d_o),     32'(0));
    chk("rst_dec_valid", 32'(dec_valid_o), 32'(0));
    chk("rst_dec_bit",   32'(dec_d_o),     32'(0));
`ifdef VITERBI_ERR_CNT_EN
    chk("rst_err_cnt",   32'(err_cnt_o),   32'(0));
`endif
    rst = 1'b0;
    m_s = 2'b00;
    bit_q.delete();
    sym_q.delete();
    pend_v  = 1'b0;
    pend_d  = 2'b00;
    dec_cnt = 0;
    n_out   = 0;
    n_cons  = 0;
  endtask

  initial begin
    int       gs, cyc, dsym, last_err;
    bit       en, b, did_rst;
    bit [1:0] err;

    do_reset();

    for (int i = 0; i < 6; i++) begin
      enc_enable_i = 1'b1;
      enc_d_i      = kv_bits[i];
      @(posedge clk); #1;
      chk("kv_valid", 32'(enc_valid_o), 32'(1));
      chk("kv_sym",   32'(enc_d_o),     32'(kv_exp[i]));
    end
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b1;
    @(posedge clk); #1;
    chk("kv_idle_valid", 32'(enc_valid_o), 32'(0));
    chk("kv_idle_hold",  32'(enc_d_o),     32'(2'b11));

    do_reset();
    gs = 0; cyc = 0; dsym = 0; last_err = -100; did_rst = 1'b0;
    while ((gs < N_SYM || pend_v) && cyc < MAX_CYC) begin
      cyc++;
      if (gs == 600 && !did_rst) begin
        did_rst = 1'b1;
        do_reset();
        continue;
      end
      en = (gs < N_SYM);
      if (en && gs >= 430 && gs < 550) en = ($urandom_range(3) != 0);
      b = 1'($urandom_range(1));

      err = 2'b00;
      if (pend_v) begin
        if (dsym >= 256 && dsym < 400 && $urandom_range(7) == 7 && dsym - last_err >= 5) begin
          err = 2'b01;
          last_err = dsym;
        end
        if (dsym == 420) err = 2'b11;
      end
      dec_enable_i = pend_v;
      dec_d_i      = pend_d ^ err;
      enc_enable_i = en;
      enc_d_i      = b;

      if (en) begin
        sym_q.push_back({b ^ m_s[1] ^ m_s[0], b ^ m_s[0]});
        bit_q.push_back(b);
        m_s = {b, m_s[1]};
        gs++;
      end
      if (pend_v) begin
        dsym++;
        n_cons++;
        if (dec_cnt < TBD) dec_cnt++;
      end

      @(posedge clk); #1;
      chk("enc_valid", 32'(enc_valid_o), 32'(en));
      if (enc_valid_o) begin
        if (sym_q.size() == 0) chk("enc_underflow", 32'(1), 32'(0));
        else chk("enc_sym", 32'(enc_d_o), 32'(sym_q.pop_front()));
      end
      chk("dec_valid", 32'(dec_valid_o), 32'(pend_v && dec_cnt >= TBD));
      if (dec_valid_o) begin
        n_out++;
        if (bit_q.size() == 0) chk("dec_underflow", 32'(1), 32'(0));
        else chk("dec_bit", 32'(dec_d_o), 32'(bit_q.pop_front()));
      end
      pend_v = enc_valid_o;
      pend_d = enc_d_o;
    end

    chk("timeout",   32'(cyc < MAX_CYC), 32'(1));
    chk("out_count", 32'(n_out),         32'(n_cons - (TBD - 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
